// File: rtl/fc_tx_arbiter_if.sv
// Request/grant bundle between the per-class TLP queues and the credit-aware TX arbiter.
// Class slices: bit/slice 0 = P, 1 = NP, 2 = CPL.
interface fc_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [2:0]              req;
  logic [3*DATA_WIDTH-1:0] hdr_need;
  logic [3*DATA_WIDTH-1:0] data_need;
  logic                    tx_done;
  logic [2:0]              gnt;
  logic                    busy;
  logic [2:0]              blocked;

  modport master (output req, hdr_need, data_need, tx_done, input gnt, busy, blocked);
  modport slave  (input req, hdr_need, data_need, tx_done, output gnt, busy, blocked);
endinterface

// File: rtl/fc_tx_arbiter.sv
// VC0 credit-aware round-robin TX arbiter for P / NP / CPL requesters.
// Grants one TLP at a time and tracks the six credits-consumed counters.
module fc_tx_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fc_tx_arbiter_if.slave        bus,
  input  logic [DATA_WIDTH-1:0] PH_credit_limit,
  input  logic [DATA_WIDTH-1:0] PD_credit_limit,
  input  logic [DATA_WIDTH-1:0] NPH_credit_limit,
  input  logic [DATA_WIDTH-1:0] NPD_credit_limit,
  input  logic [DATA_WIDTH-1:0] CH_credit_limit,
  input  logic [DATA_WIDTH-1:0] CD_credit_limit,
  output logic [DATA_WIDTH-1:0] PH_credit_consumed,
  output logic [DATA_WIDTH-1:0] PD_credit_consumed,
  output logic [DATA_WIDTH-1:0] NPH_credit_consumed,
  output logic [DATA_WIDTH-1:0] NPD_credit_consumed,
  output logic [DATA_WIDTH-1:0] CH_credit_consumed,
  output logic [DATA_WIDTH-1:0] CD_credit_consumed
);
  localparam int           W    = DATA_WIDTH;
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};
  localparam logic [1:0]   CLS_CPL = 2'd2;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state, next_state;
  logic [W-1:0] lim_h  [3];
  logic [W-1:0] lim_d  [3];
  logic [W-1:0] cons_h [3];
  logic [W-1:0] cons_d [3];
  logic [W-1:0] need_h [3];
  logic [W-1:0] need_d [3];
  logic [2:0]   credit_ok;
  logic [2:0]   eligible;
  logic [1:0]   ptr;
  logic [1:0]   win_idx;
  logic         win_found;
  logic         grant_en;
  logic [2:0]   gnt_q, gnt_d;

  assign lim_h[0] = PH_credit_limit;
  assign lim_d[0] = PD_credit_limit;
  assign lim_h[1] = NPH_credit_limit;
  assign lim_d[1] = NPD_credit_limit;
  assign lim_h[2] = CH_credit_limit;
  assign lim_d[2] = CD_credit_limit;

  assign PH_credit_consumed  = cons_h[0];
  assign PD_credit_consumed  = cons_d[0];
  assign NPH_credit_consumed = cons_h[1];
  assign NPD_credit_consumed = cons_d[1];
  assign CH_credit_consumed  = cons_h[2];
  assign CD_credit_consumed  = cons_d[2];

  // Modulo-2^W headroom test; a zero need never consumes credit, so it always fits.
  function automatic logic fits(input logic [W-1:0] limit,
                                input logic [W-1:0] used,
                                input logic [W-1:0] need);
    logic [W-1:0] headroom;
    headroom = limit - (used + need);
    return (need == '0) || (headroom <= HALF);
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_cls
    assign need_h[i]    = bus.hdr_need[i*W +: W];
    assign need_d[i]    = bus.data_need[i*W +: W];
    assign credit_ok[i] = fits(lim_h[i], cons_h[i], need_h[i]) &&
                          fits(lim_d[i], cons_d[i], need_d[i]);
  end

  assign eligible    = bus.req & credit_ok;
  assign bus.blocked = bus.req & ~credit_ok;
  assign bus.busy    = (state == BUSY);
  assign bus.gnt     = gnt_q;

  // Search starts one past the last winner and wraps P -> NP -> CPL -> P.
  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == CLS_CPL) ? 2'd0 : cand + 2'd1;
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    gnt_d      = '0;
    grant_en   = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          next_state = BUSY;
          gnt_d      = 3'b001 << win_idx;
          grant_en   = 1'b1;
        end
      end
      BUSY: begin
        if (bus.tx_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: the consumed counters are real architectural state, so reset clears them explicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= CLS_CPL;
      gnt_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cons_h[i] <= '0;
        cons_d[i] <= '0;
      end
    end else begin
      gnt_q <= gnt_d;
      if (grant_en) begin
        ptr             <= win_idx;
        cons_h[win_idx] <= cons_h[win_idx] + need_h[win_idx];
        cons_d[win_idx] <= cons_d[win_idx] + need_d[win_idx];
      end
    end
  end
endmodule

// File: tb/tb_fc_tx_arbiter.sv
// Self-checking bench for fc_tx_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural credit/round-robin model.
module tb_fc_tx_arbiter;
  localparam int W    = 8;
  localparam int MOD  = 1 << W;
  localparam int HALF = MOD / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] lim_h  [3];
  logic [W-1:0] lim_d  [3];
  logic [W-1:0] cons_h [3];
  logic [W-1:0] cons_d [3];
  logic [W-1:0] nh     [3];
  logic [W-1:0] nd     [3];

  int checks = 0;
  int errors = 0;

  fc_tx_arbiter_if #(.DATA_WIDTH(W)) bus ();

  assign bus.hdr_need  = {nh[2], nh[1], nh[0]};
  assign bus.data_need = {nd[2], nd[1], nd[0]};

  fc_tx_arbiter #(.DATA_WIDTH(W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus),
    .PH_credit_limit     (lim_h[0]),
    .PD_credit_limit     (lim_d[0]),
    .NPH_credit_limit    (lim_h[1]),
    .NPD_credit_limit    (lim_d[1]),
    .CH_credit_limit     (lim_h[2]),
    .CD_credit_limit     (lim_d[2]),
    .PH_credit_consumed  (cons_h[0]),
    .PD_credit_consumed  (cons_d[0]),
    .NPH_credit_consumed (cons_h[1]),
    .NPD_credit_consumed (cons_d[1]),
    .CH_credit_consumed  (cons_h[2]),
    .CD_credit_consumed  (cons_d[2])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_valid = 1'b0;
  bit         m_busy;
  int         m_ptr;
  int         m_ch [3];
  int         m_cd [3];
  logic [2:0] m_gnt;

  function automatic bit m_fits(input int limit, input int used, input int need);
    int head;
    head = (((limit - used - need) % MOD) + MOD) % MOD;
    return (need == 0) || (head <= HALF);
  endfunction

  function automatic logic [2:0] m_blocked();
    logic [2:0] b;
    b = '0;
    for (int i = 0; i < 3; i++)
      if (bus.req[i] && !(m_fits(int'(lim_h[i]), m_ch[i], int'(nh[i])) &&
                          m_fits(int'(lim_d[i]), m_cd[i], int'(nd[i]))))
        b[i] = 1'b1;
    return b;
  endfunction

  always @(posedge clk) begin
    logic [2:0] elig;
    int         pick;
    if (rst) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_ptr   = 2;
      m_gnt   = '0;
      for (int i = 0; i < 3; i++) begin
        m_ch[i] = 0;
        m_cd[i] = 0;
      end
    end else if (m_busy) begin
      m_gnt = '0;
      if (bus.tx_done) m_busy = 1'b0;
    end else begin
      elig  = bus.req & ~m_blocked();
      m_gnt = '0;
      pick  = 0;
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_ptr + k) % 3;
        if (elig[c] && m_gnt == 3'b000) begin
          m_gnt = 3'b001 << c;
          pick  = c;
        end
      end
      if (m_gnt != 3'b000) begin
        m_busy     = 1'b1;
        m_ch[pick] = (m_ch[pick] + int'(nh[pick])) % MOD;
        m_cd[pick] = (m_cd[pick] + int'(nd[pick])) % MOD;
        m_ptr      = pick;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_gnt", 32'(bus.gnt), 32'(m_gnt));
      check("cmp_busy", 32'(bus.busy), 32'(m_busy));
      check("cmp_blocked", 32'(bus.blocked), 32'(m_blocked()));
      for (int i = 0; i < 3; i++) begin
        check($sformatf("cmp_cons_h%0d", i), 32'(cons_h[i]), 32'(m_ch[i]));
        check($sformatf("cmp_cons_d%0d", i), 32'(cons_d[i]), 32'(m_cd[i]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic grant_slot(output logic [2:0] g);
    cyc(1);
    g = bus.gnt;
    bus.tx_done = 1'b1;
    cyc(1);
    bus.tx_done = 1'b0;
  endtask

  task automatic set_all(input logic [W-1:0] lim, input logic [W-1:0] hneed,
                         input logic [W-1:0] dneed);
    for (int i = 0; i < 3; i++) begin
      lim_h[i] = lim;
      lim_d[i] = lim;
      nh[i]    = hneed;
      nd[i]    = dneed;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.tx_done = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g;
    logic [2:0] rr_exp [4];
    logic [2:0] blk_exp [6];

    rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001};
    blk_exp = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b001};

    // Model pins at the modulo boundaries.
    check("model_half_passes", 32'(m_fits(129, 0, 1)), 32'd1);
    check("model_half_plus1_blocks", 32'(m_fits(0, 0, 127)), 32'd0);
    check("model_wrap_passes", 32'(m_fits(4, 250, 2)), 32'd1);

    // 1. Reset and single grant.
    set_all(8'd8, 8'd0, 8'd0);
    nh[0] = 8'd1;
    nd[0] = 8'd4;
    do_reset();
    check("reset_gnt", 32'(bus.gnt), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_ph", 32'(cons_h[0]), 32'd0);
    check("reset_cd", 32'(cons_d[2]), 32'd0);
    bus.req = 3'b001;
    cyc(1);
    check("t1_gnt", 32'(bus.gnt), 32'b001);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_ph", 32'(cons_h[0]), 32'd1);
    check("t1_pd", 32'(cons_d[0]), 32'd4);
    bus.req = 3'b000;
    cyc(1);
    check("t1_gnt_pulse", 32'(bus.gnt), 32'd0);
    check("t1_busy_hold", 32'(bus.busy), 32'd1);
    bus.tx_done = 1'b1;
    cyc(1);
    bus.tx_done = 1'b0;
    check("t1_busy_done", 32'(bus.busy), 32'd0);

    // 2. Round robin, one grant per two cycles.
    set_all(8'd100, 8'd1, 8'd1);
    do_reset();
    bus.req = 3'b111;
    for (int s = 0; s < 4; s++) begin
      grant_slot(g);
      check($sformatf("t2_rr%0d", s), 32'(g), 32'(rr_exp[s]));
    end

    // 3. Credit block on NP, P bypasses it, then limit raise unblocks NP.
    set_all(8'd100, 8'd1, 8'd1);
    lim_h[1] = 8'd2;
    do_reset();
    bus.req = 3'b011;
    for (int s = 0; s < 6; s++) begin
      grant_slot(g);
      check($sformatf("t3_slot%0d", s), 32'(g), 32'(blk_exp[s]));
    end
    check("t3_blocked_np", 32'(bus.blocked), 32'b010);
    check("t3_nph", 32'(cons_h[1]), 32'd2);
    lim_h[1] = 8'd3;
    #1;
    check("t3_unblocked", 32'(bus.blocked), 32'b000);
    grant_slot(g);
    check("t3_np_after_raise", 32'(g), 32'b010);

    // Boundary: headroom exactly half passes, half+1 blocks, zero need always passes.
    set_all(8'd100, 8'd0, 8'd0);
    do_reset();
    bus.req = 3'b001;
    lim_h[0] = 8'd129;
    nh[0] = 8'd1;
    #1;
    check("bnd_half", 32'(bus.blocked), 32'b000);
    lim_h[0] = 8'd0;
    nh[0] = 8'd127;
    #1;
    check("bnd_half_plus1", 32'(bus.blocked), 32'b001);
    nh[0] = 8'd0;
    #1;
    check("bnd_zero_need", 32'(bus.blocked), 32'b000);
    bus.req = 3'b000;

    // 4. Wrap-around of the PH counter.
    set_all(8'd250, 8'd0, 8'd0);
    do_reset();
    nh[0] = 8'd125;
    bus.req = 3'b001;
    grant_slot(g);
    grant_slot(g);
    check("t4_ph250", 32'(cons_h[0]), 32'd250);
    lim_h[0] = 8'd4;
    nh[0] = 8'd2;
    grant_slot(g);
    check("t4_wrap_gnt", 32'(g), 32'b001);
    check("t4_ph252", 32'(cons_h[0]), 32'd252);
    lim_h[0] = 8'd251;
    #1;
    check("t4_blocked", 32'(bus.blocked), 32'b001);
    grant_slot(g);
    check("t4_no_gnt", 32'(g), 32'b000);
    check("t4_idle", 32'(bus.busy), 32'd0);
    check("t4_ph_hold", 32'(cons_h[0]), 32'd252);
    bus.req = 3'b000;

    // 5. Reset while a CPL grant is outstanding.
    set_all(8'd100, 8'd1, 8'd1);
    do_reset();
    bus.req = 3'b100;
    cyc(1);
    check("t5_cpl_gnt", 32'(bus.gnt), 32'b100);
    check("t5_ch", 32'(cons_h[2]), 32'd1);
    bus.req = 3'b000;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_gnt", 32'(bus.gnt), 32'd0);
    check("t5_ch_clr", 32'(cons_h[2]), 32'd0);
    check("t5_cd_clr", 32'(cons_d[2]), 32'd0);
    bus.req = 3'b111;
    cyc(1);
    check("t5_first_gnt", 32'(bus.gnt), 32'b001);

    // 6. Request changes during BUSY, and tx_done in IDLE, are ignored.
    bus.req = 3'b110;
    for (int s = 0; s < 3; s++) begin
      cyc(1);
      check($sformatf("t6_nogrant%0d", s), 32'(bus.gnt), 32'd0);
      check($sformatf("t6_busy%0d", s), 32'(bus.busy), 32'd1);
    end
    bus.req = 3'b000;
    bus.tx_done = 1'b1;
    cyc(1);
    check("t6_released", 32'(bus.busy), 32'd0);
    cyc(1);
    bus.tx_done = 1'b0;
    check("t6_idle_done_busy", 32'(bus.busy), 32'd0);
    check("t6_idle_done_gnt", 32'(bus.gnt), 32'd0);
    bus.req = 3'b010;
    cyc(1);
    check("t6_np_gnt", 32'(bus.gnt), 32'b010);
    bus.tx_done = 1'b1;
    cyc(1);
    bus.tx_done = 1'b0;

    // Randomized traffic, checked every cycle by the compare process.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom_range(0, 599) == 0);
      bus.req     = 3'($urandom);
      bus.tx_done = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 3; i++) begin
        nh[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
        nd[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 16));
        if ($urandom_range(0, 3) == 0) lim_h[i] = 8'(m_ch[i] + int'($urandom_range(0, 10)));
        if ($urandom_range(0, 3) == 0) lim_d[i] = 8'(m_cd[i] + int'($urandom_range(0, 40)));
        if ($urandom_range(0, 49) == 0) lim_h[i] = 8'($urandom);
      end
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
